// File: rtl/regfile_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;

    function automatic int unsigned byte_count(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-producer scoreboard: one bit per register, set by reserve, cleared by writeback.
module regfile_mp_sb
    import regfile_mp_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    input  logic                     act0,
    input  logic [ADDR_W-1:0]        wn0,
    input  logic                     act1,
    input  logic [ADDR_W-1:0]        wn1,
    input  logic                     rsv,
    input  logic [ADDR_W-1:0]        rsv_n,
    output logic [NUM_RD-1:0]        busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;

    // A new reservation outranks a same-cycle writeback; entry 0 is never touched.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (rsv && (rsv_n == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if ((act0 && (wn0 == ADDR_W'(i))) ||
                             (act1 && (wn1 == ADDR_W'(i)))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = ra[k*ADDR_W +: ADDR_W];
        assign hit  = BYPASS && ((act0 && (wn0 == addr)) || (act1 && (wn1 == addr)));
        assign busy[k] = (addr != '0) && pending[addr] && !hit;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with byte-enabled dual writeback and optional bypass.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [NUM_RD*ADDR_W-1:0]      ra,
    output logic [NUM_RD*DATA_W-1:0]      q,
    output logic [NUM_RD-1:0]             busy,
    input  logic                          we0,
    input  logic [ADDR_W-1:0]             wn0,
    input  logic [byte_count(DATA_W)-1:0] be0,
    input  logic [DATA_W-1:0]             d0,
    input  logic                          we1,
    input  logic [ADDR_W-1:0]             wn1,
    input  logic [byte_count(DATA_W)-1:0] be1,
    input  logic [DATA_W-1:0]             d1,
    input  logic                          rsv,
    input  logic [ADDR_W-1:0]             rsv_n
);

    localparam int unsigned NB    = byte_count(DATA_W);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    if ((DATA_W % 8 != 0) || (NUM_RD < 1) || (NUM_RD > 4)) begin : g_param_err
        $error("regfile_mp: DATA_W must be a multiple of 8 and NUM_RD within 1..4");
    end

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    logic              act0;
    logic              act1;
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] mem_nxt [DEPTH];

    assign act0 = we0 && (wn0 != '0);
    assign act1 = we1 && (wn1 != '0);

    // Port 0 merged first so port 1 overrides it on overlapping enabled bytes.
    always_comb begin
        mem_nxt = mem;
        for (int i = 1; i < DEPTH; i++) begin
            if (act0 && (wn0 == ADDR_W'(i))) mem_nxt[i] = merge_bytes(mem_nxt[i], d0, be0);
            if (act1 && (wn1 == ADDR_W'(i))) mem_nxt[i] = merge_bytes(mem_nxt[i], d1, be1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem_nxt[i];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] rd_val;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_val = mem[addr];
            if (BYPASS) begin
                if (act0 && (wn0 == addr)) rd_val = merge_bytes(rd_val, d0, be0);
                if (act1 && (wn1 == addr)) rd_val = merge_bytes(rd_val, d1, be1);
            end
            if (addr == '0) rd_val = '0;
        end

        assign q[k*DATA_W +: DATA_W] = rd_val;
    end

    regfile_mp_sb #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk   (clk),
        .clrn  (clrn),
        .ra    (ra),
        .act0  (act0),
        .wn0   (wn0),
        .act1  (act1),
        .wn1   (wn1),
        .rsv   (rsv),
        .rsv_n (rsv_n),
        .busy  (busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        clrn;
    logic [9:0]  ra;
    logic [63:0] q,  q_nb;
    logic [1:0]  busy, busy_nb;
    logic        we0, we1, rsv;
    logic [4:0]  wn0, wn1, rsv_n;
    logic [3:0]  be0, be1;
    logic [31:0] d0, d1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1)) dut (
        .clk(clk), .clrn(clrn), .ra(ra), .q(q), .busy(busy),
        .we0(we0), .wn0(wn0), .be0(be0), .d0(d0),
        .we1(we1), .wn1(wn1), .be1(be1), .d1(d1),
        .rsv(rsv), .rsv_n(rsv_n)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .clrn(clrn), .ra(ra), .q(q_nb), .busy(busy_nb),
        .we0(we0), .wn0(wn0), .be0(be0), .d0(d0),
        .we1(we1), .wn1(wn1), .be1(be1), .d1(d1),
        .rsv(rsv), .rsv_n(rsv_n)
    );

    typedef struct {
        logic        we0;
        logic [4:0]  wn0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  wn1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        rsv;
        logic [4:0]  rsv_n;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] eq0;
        logic [31:0] eq1;
        logic [1:0]  ebusy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w0, logic [4:0] n0, logic [3:0] b0, logic [31:0] x0,
                                logic w1, logic [4:0] n1, logic [3:0] b1, logic [31:0] x1,
                                logic r, logic [4:0] rn, logic [4:0] a0, logic [4:0] a1,
                                logic [31:0] e0, logic [31:0] e1, logic [1:0] eb);
        vec_t v;
        v.we0 = w0; v.wn0 = n0; v.be0 = b0; v.d0 = x0;
        v.we1 = w1; v.wn1 = n1; v.be1 = b1; v.d1 = x1;
        v.rsv = r;  v.rsv_n = rn; v.ra0 = a0; v.ra1 = a1;
        v.eq0 = e0; v.eq1 = e1; v.ebusy = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        we0 = v.we0; wn0 = v.wn0; be0 = v.be0; d0 = v.d0;
        we1 = v.we1; wn1 = v.wn1; be1 = v.be1; d1 = v.d1;
        rsv = v.rsv; rsv_n = v.rsv_n;
        ra  = {v.ra1, v.ra0};
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a0, a1, 0, 0, 0));
    endtask

    initial begin
        clrn = 1'b0;
        idle(5'd3, 5'd5);
        @(negedge clk);
        #2;
        chk("reset q0", q[31:0], 32'h0);
        chk("reset q1", q[63:32], 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        @(negedge clk);
        clrn = 1'b1;

        //      we0 wn0 be0  d0            we1 wn1 be1  d1            rsv rn ra0 ra1 eq0           eq1           busy
        vecs.push_back(mk(1, 3, 4'hF, 32'h11223344, 0, 0, 4'h0, 32'h0,        0, 0, 3, 0, 32'h11223344, 32'h0,        2'b00));
        vecs.push_back(mk(1, 3, 4'h5, 32'hAABBCCDD, 0, 0, 4'h0, 32'h0,        0, 0, 3, 3, 32'h11BB33DD, 32'h11BB33DD, 2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 3, 5, 32'h11BB33DD, 32'h0,        2'b00));
        vecs.push_back(mk(1, 7, 4'hF, 32'h0000FFFF, 1, 7, 4'h3, 32'h12345678, 0, 0, 7, 7, 32'h00005678, 32'h00005678, 2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 7, 3, 32'h00005678, 32'h11BB33DD, 2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 4, 4, 4, 32'h0,        32'h0,        2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 4, 0, 32'h0,        32'h0,        2'b01));
        vecs.push_back(mk(1, 4, 4'hF, 32'h00000044, 0, 0, 4'h0, 32'h0,        1, 4, 4, 5, 32'h00000044, 32'h0,        2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 4, 0, 32'h00000044, 32'h0,        2'b01));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        1, 4, 4'hF, 32'h44440000, 0, 0, 4, 4, 32'h44440000, 32'h44440000, 2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 4, 4, 32'h44440000, 32'h44440000, 2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        1, 6, 6, 0, 32'h0,        32'h0,        2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 6, 6, 32'h0,        32'h0,        2'b11));
        vecs.push_back(mk(1, 6, 4'h0, 32'hFFFFFFFF, 0, 0, 4'h0, 32'h0,        0, 0, 6, 6, 32'h0,        32'h0,        2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 6, 6, 32'h0,        32'h0,        2'b00));
        vecs.push_back(mk(1, 0, 4'hF, 32'hFFFFFFFF, 1, 0, 4'hF, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0,        32'h0,        2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        1, 9, 4'hF, 32'hCAFEF00D, 0, 0, 9, 3, 32'hCAFEF00D, 32'h11BB33DD, 2'b00));
        vecs.push_back(mk(0, 0, 4'h0, 32'h0,        0, 0, 4'h0, 32'h0,        0, 0, 9, 3, 32'hCAFEF00D, 32'h11BB33DD, 2'b00));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk($sformatf("v%0d q0", i), q[31:0], vecs[i].eq0);
            chk($sformatf("v%0d q1", i), q[63:32], vecs[i].eq1);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].ebusy));
        end

        // Non-bypass instance sees old data until the edge; bypass sees new data at once.
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 1, 9, 4'hF, 32'h0BADC0DE, 0, 0, 9, 9, 0, 0, 0));
        #2;
        chk("nb old before edge", q_nb[31:0], 32'hCAFEF00D);
        chk("byp new before edge", q[31:0], 32'h0BADC0DE);
        @(negedge clk);
        idle(5'd9, 5'd9);
        #2;
        chk("nb new after edge", q_nb[31:0], 32'h0BADC0DE);

        // Non-bypass busy is not masked by a same-cycle writeback.
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 0));
        @(negedge clk);
        drive(mk(1, 9, 4'hF, 32'h00000009, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 0));
        #2;
        chk("nb busy during write", 32'(busy_nb), 32'h3);
        chk("byp busy during write", 32'(busy), 32'h0);
        @(negedge clk);
        idle(5'd9, 5'd9);
        #2;
        chk("nb busy after write", 32'(busy_nb), 32'h0);
        chk("nb q after write", q_nb[31:0], 32'h00000009);

        // Mid-cycle reset clears data and pending at once, and discards a write held during reset.
        @(negedge clk);
        drive(mk(1, 5, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 5, 5, 3, 0, 0, 0));
        @(negedge clk);
        idle(5'd5, 5'd3);
        #2;
        chk("pre-reset q", q[31:0], 32'hDEADBEEF);
        chk("pre-reset busy", 32'(busy), 32'h1);
        #1;
        clrn = 1'b0;
        #1;
        chk("in-reset q0", q[31:0], 32'h0);
        chk("in-reset q1", q[63:32], 32'h0);
        chk("in-reset busy", 32'(busy), 32'h0);
        drive(mk(1, 5, 4'hF, 32'h12345678, 0, 0, 0, 0, 1, 5, 5, 3, 0, 0, 0));
        @(negedge clk);
        idle(5'd5, 5'd3);
        clrn = 1'b1;
        #2;
        chk("post-reset q", q[31:0], 32'h0);
        chk("post-reset busy", 32'(busy), 32'h0);
        chk("post-reset nb q", q_nb[31:0], 32'h0);
        @(negedge clk);
        #2;
        chk("post-reset q settled", q[31:0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
